null_symbol_inserter: RTL and testbench
=======================================

Name: null_symbol_inserter

Overview:
Transmit-side counterpart of the null symbol detector.
- Takes a continuous AXI4-Stream of complex baseband samples (16-bit I, 16-bit Q).
- Frames the stream by emitting a programmable run of zero-valued "null" samples before each block of FRAME_LEN passed-through samples.
- Marks the last data sample of each frame with tlast.
- Sits between the OFDM IFFT/CP stage and the DAC stream interface; its configuration comes from the AXI-Lite register block.

Parameters:
DATA_WIDTH, 32, sample width (I in [31:16], Q in [15:0])
LEN_WIDTH, 16, width of null/frame length configuration and counters

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
cfg_enable  in  1  start/continue framing; sampled only at frame boundaries
cfg_null_len  in  LEN_WIDTH  number of null samples per frame (0 = no null period)
cfg_frame_len  in  LEN_WIDTH  number of data samples per frame (0 = block will not start)
s_axis_tdata  in  DATA_WIDTH  input sample
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_WIDTH  output sample
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last data sample of frame
m_axis_tuser  out  1  1 = null sample
busy  out  1  state != IDLE
frame_count  out  32  completed frames, wraps at 2^32

Behaviour:
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, tlast=0, tuser=0, busy=0, frame_count=0, state=IDLE, counters=0. Reset asserted mid-frame aborts immediately; no partial frame completion.
- Output is a single register stage. m_axis_* may change only when m_axis_tvalid=0 or m_axis_tready=1 (AXIS hold rule). Output accept = m_axis_tvalid & m_axis_tready.
- FSM IDLE:
  - On the cycle that satisfies cfg_enable=1 and cfg_frame_len!=0, latch null_len and frame_len.
  - Go to NULL if null_len!=0, else DATA.
  - s_axis_tready=0 while in IDLE.
- FSM NULL:
  - s_axis_tready=0.
  - Load output with tdata=0, tuser=1, tlast=0 whenever the register is free.
  - Count loaded null samples. After the null_len-th null sample is loaded, go to DATA.
  - Input is never consumed during NULL.
- FSM DATA:
  - s_axis_tready = (m_axis_tvalid=0 or m_axis_tready=1) and data count < frame_len.
  - Each input handshake loads s_axis_tdata into the output with tuser=0. The load is the first-word-fall-through path with exactly 1 cycle latency.
  - tlast=1 on the frame_len-th data sample.
  - Input s_axis tlast (absent) is not used.
  - After loading the last data sample:
    - cfg_enable=1: re-latch lengths and go to NULL (or DATA if null_len=0). The next frame's first sample may load on the cycle after the last one is accepted, so there are no bubbles when m_axis_tready=1.
    - cfg_enable=0: go to IDLE once the last sample is accepted. busy stays 1 until that acceptance.
- frame_count increments on acceptance of the tlast sample.
- Configuration changes mid-frame have no effect until the next boundary. cfg_enable deassertion mid-frame finishes the current frame.
- Counters are LEN_WIDTH bits; max null_len/frame_len = 2^LEN_WIDTH-1, with no wrap inside a frame.
- Simultaneous input handshake and output accept in DATA: the new sample replaces the old one in the same cycle. No data is lost or duplicated.

Decomposition:
- Shared include file null_symbol_defs.vh: state encodings (IDLE=2'd0, NULL=2'd1, DATA=2'd2), sample field offsets, default lengths.
- One natural sub-module, axis_out_reg: a single-stage AXIS output register with a load/hold interface.
- The FSM and counters stay in the top level.

Test Plan:
- Reset check: hold ARESET, drive random inputs -> all outputs at reset values. Release reset with cfg_enable=0 -> busy=0, s_axis_tready=0.
- Basic frame: null_len=4, frame_len=3, input 0x00010002, 0x00030004, 0x00050006, m_axis_tready=1, cfg_enable dropped after start.
  - Output is 4 beats of tdata=0/tuser=1, then the 3 inputs in order with tuser=0, tlast only on 0x00050006.
  - Afterwards frame_count=1 and busy=0.
- Backpressure: same config, m_axis_tready toggled 1010... and s_axis_tvalid randomized -> output sequence identical to the basic frame, tdata stable while tvalid=1 and tready=0.
- Back-to-back frames: cfg_enable held 1, null_len=2, frame_len=2, input 0x01..0x08 -> pattern N,N,1,2(last),N,N,3,4(last)... with no idle cycles; frame_count=4 after 4 frames.
- null_len=0, frame_len=1 -> every output beat is data with tlast=1, tuser=0.
- Reset mid-frame: assert ARESET during the NULL state (2nd null beat) -> next cycle all outputs are at reset values. Re-enable -> a full null run of null_len restarts, and frame_count restarts at 0.

Source files
------------

// File: rtl/null_symbol_inserter_pkg.sv
// Shared types and helpers for the null symbol inserter: FSM state encoding
// and the end-of-run test used by both the null and data counters.
package null_symbol_inserter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NULL = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // True when cnt is the index of the final item of a run of length len.
    function automatic logic is_final(input logic [31:0] cnt, input logic [31:0] len);
        return (len != 32'd0) && (cnt == len - 32'd1);
    endfunction

endpackage

// File: rtl/null_symbol_inserter_if.sv
// AXI4-Stream sample bus used on both sides of the null symbol inserter.
interface null_symbol_inserter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, input tready, output tlast, output tuser);
    modport slave  (input tdata, input tvalid, output tready, input tlast, input tuser);
endinterface

// File: rtl/null_symbol_inserter_axis_out_reg.sv
// Single-stage AXI4-Stream output register: load overwrites the stage,
// otherwise it holds until the downstream accepts it.
module axis_out_reg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  load_user,
    output logic                  free,
    output logic                  accept,
    output logic                  accept_last,
    null_symbol_inserter_if.master m
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  user_q, user_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        user_d  = user_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
            user_d  = load_user;
        end else if (valid_q && m.tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

    assign free        = !valid_q || m.tready;
    assign accept      = valid_q && m.tready;
    assign accept_last = valid_q && m.tready && last_q;

    assign m.tvalid = valid_q;
    assign m.tdata  = data_q;
    assign m.tlast  = last_q;
    assign m.tuser  = user_q;

endmodule

// File: rtl/null_symbol_inserter.sv
// Frames a continuous sample stream: a run of null (zero, tuser=1) samples
// followed by frame_len passed-through samples, tlast on the final one.
module null_symbol_inserter
    import null_symbol_inserter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 cfg_enable,
    input  logic [LEN_WIDTH-1:0] cfg_null_len,
    input  logic [LEN_WIDTH-1:0] cfg_frame_len,
    null_symbol_inserter_if.slave  s_axis,
    null_symbol_inserter_if.master m_axis,
    output logic                 busy,
    output logic [31:0]          frame_count
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  null_len_q, null_len_d;
    logic [LEN_WIDTH-1:0]  frame_len_q, frame_len_d;
    logic [LEN_WIDTH-1:0]  null_cnt_q, null_cnt_d;
    logic [LEN_WIDTH-1:0]  data_cnt_q, data_cnt_d;
    logic [31:0]           frame_count_q, frame_count_d;

    logic                  out_load, out_last, out_user;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_free, out_accept, out_accept_last;
    logic                  s_ready, start_ok, data_final;
    logic                  unused_s;

    assign unused_s = ^{s_axis.tlast, s_axis.tuser};
    assign start_ok = cfg_enable && (cfg_frame_len != '0);

    always_comb begin
        state_d       = state_q;
        null_len_d    = null_len_q;
        frame_len_d   = frame_len_q;
        null_cnt_d    = null_cnt_q;
        data_cnt_d    = data_cnt_q;
        frame_count_d = frame_count_q;
        out_load      = 1'b0;
        out_data      = '0;
        out_last      = 1'b0;
        out_user      = 1'b0;
        s_ready       = 1'b0;
        data_final    = is_final(32'(data_cnt_q), 32'(frame_len_q));

        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    null_len_d  = cfg_null_len;
                    frame_len_d = cfg_frame_len;
                    null_cnt_d  = '0;
                    data_cnt_d  = '0;
                    state_d     = (cfg_null_len != '0) ? ST_NULL : ST_DATA;
                end
            end
            ST_NULL: begin
                if (out_free) begin
                    out_load   = 1'b1;
                    out_user   = 1'b1;
                    null_cnt_d = null_cnt_q + LEN_ONE;
                    if (is_final(32'(null_cnt_q), 32'(null_len_q))) begin
                        data_cnt_d = '0;
                        state_d    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                s_ready = out_free && (data_cnt_q < frame_len_q);
                if (s_ready && s_axis.tvalid) begin
                    out_load   = 1'b1;
                    out_data   = s_axis.tdata;
                    out_last   = data_final;
                    data_cnt_d = data_cnt_q + LEN_ONE;
                    // Boundary: re-arm straight away so the next frame loads
                    // behind the last sample without a bubble.
                    if (data_final && start_ok) begin
                        null_len_d  = cfg_null_len;
                        frame_len_d = cfg_frame_len;
                        null_cnt_d  = '0;
                        data_cnt_d  = '0;
                        state_d     = (cfg_null_len != '0) ? ST_NULL : ST_DATA;
                    end
                end else if ((data_cnt_q == frame_len_q) && out_accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (out_accept_last) frame_count_d = frame_count_q + 32'd1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= ST_IDLE;
            null_len_q    <= '0;
            frame_len_q   <= '0;
            null_cnt_q    <= '0;
            data_cnt_q    <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            null_len_q    <= null_len_d;
            frame_len_q   <= frame_len_d;
            null_cnt_q    <= null_cnt_d;
            data_cnt_q    <= data_cnt_d;
            frame_count_q <= frame_count_d;
        end
    end

    axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
        .clk         (ACLK),
        .rst         (ARESET),
        .load        (out_load),
        .load_data   (out_data),
        .load_last   (out_last),
        .load_user   (out_user),
        .free        (out_free),
        .accept      (out_accept),
        .accept_last (out_accept_last),
        .m           (m_axis)
    );

    assign s_axis.tready = s_ready;
    assign busy          = (state_q != ST_IDLE);
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_null_symbol_inserter.sv
// Directed and randomized checks of null_symbol_inserter against a
// frame-level reference model (null runs then data blocks).
module tb_null_symbol_inserter;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
    } beat_t;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          cfg_enable;
    logic [LW-1:0] cfg_null_len;
    logic [LW-1:0] cfg_frame_len;
    logic          busy;
    logic [31:0]   frame_count;

    null_symbol_inserter_if #(.DATA_WIDTH(DW)) s_axis ();
    null_symbol_inserter_if #(.DATA_WIDTH(DW)) m_axis ();

    null_symbol_inserter #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .cfg_enable    (cfg_enable),
        .cfg_null_len  (cfg_null_len),
        .cfg_frame_len (cfg_frame_len),
        .s_axis        (s_axis),
        .m_axis        (m_axis),
        .busy          (busy),
        .frame_count   (frame_count)
    );

    always #5 ACLK = ~ACLK;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] in_data[$];
    beat_t       exp_q[$];
    beat_t       got_q[$];
    int unsigned got_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_tvalid"}, 64'(m_axis.tvalid), 64'd0);
        check({tag, "_m_tdata"},  64'(m_axis.tdata),  64'd0);
        check({tag, "_m_tlast"},  64'(m_axis.tlast),  64'd0);
        check({tag, "_m_tuser"},  64'(m_axis.tuser),  64'd0);
        check({tag, "_s_tready"}, 64'(s_axis.tready), 64'd0);
        check({tag, "_busy"},     64'(busy),          64'd0);
        check({tag, "_frame_cnt"}, 64'(frame_count),  64'd0);
    endtask

    // ready_mode: 0 = always ready, 1 = toggle 1010..., 2 = random
    task automatic run_frames(input int unsigned nl, input int unsigned fl, input int unsigned nf,
                              input int unsigned ready_mode, input bit rand_valid,
                              input bit drop_early, input bit check_gapless);
        int unsigned total_in = fl * nf;
        int unsigned in_cnt = 0;
        int unsigned cyc = 0;
        int unsigned budget;
        logic [31:0] fc0 = frame_count;
        bit started = 0, hold = 0, consumed = 0, in_hs;
        beat_t prev, cur;
        int unsigned n;

        exp_q.delete(); got_q.delete(); got_cyc.delete();
        for (int unsigned f = 0; f < nf; f++) begin
            for (int unsigned k = 0; k < nl; k++) exp_q.push_back('{data: 32'd0, user: 1'b1, last: 1'b0});
            for (int unsigned k = 0; k < fl; k++)
                exp_q.push_back('{data: in_data[f*fl+k], user: 1'b0, last: (k == fl - 1)});
        end
        cfg_null_len  = LW'(nl);
        cfg_frame_len = LW'(fl);
        budget = 20 * exp_q.size() + 50;

        while (got_q.size() < exp_q.size() && cyc < budget) begin
            @(negedge ACLK);
            cyc++;
            case (ready_mode)
                0: m_axis.tready = 1'b1;
                1: m_axis.tready = cyc[0];
                default: m_axis.tready = 1'($urandom_range(0, 1));
            endcase
            if (!s_axis.tvalid || consumed)
                s_axis.tvalid = (in_cnt < total_in) && (rand_valid ? 1'($urandom_range(0, 1)) : 1'b1);
            s_axis.tdata = (in_cnt < total_in) ? in_data[in_cnt] : 32'd0;
            consumed = 0;
            #1;
            cur = '{data: m_axis.tdata, user: m_axis.tuser, last: m_axis.tlast};
            if (hold) begin
                check("hold_tvalid", 64'(m_axis.tvalid), 64'd1);
                check("hold_beat", {31'd0, cur.data, cur.user, cur.last},
                                   {31'd0, prev.data, prev.user, prev.last});
            end
            if (busy) started = 1;
            in_hs = s_axis.tvalid && s_axis.tready;
            cfg_enable = drop_early ? !started : ((in_cnt + (in_hs ? 1 : 0)) < total_in);
            if (in_hs) begin
                in_cnt++;
                consumed = 1;
            end
            if (m_axis.tvalid && m_axis.tready) begin
                got_q.push_back(cur);
                got_cyc.push_back(cyc);
            end
            hold = m_axis.tvalid && !m_axis.tready;
            prev = cur;
        end

        check("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            check($sformatf("beat%0d_tdata", i), 64'(got_q[i].data), 64'(exp_q[i].data));
            check($sformatf("beat%0d_tuser", i), 64'(got_q[i].user), 64'(exp_q[i].user));
            check($sformatf("beat%0d_tlast", i), 64'(got_q[i].last), 64'(exp_q[i].last));
        end
        if (check_gapless && n > 0)
            check("gapless_span", 64'(got_cyc[n-1] - got_cyc[0]), 64'(exp_q.size() - 1));

        cfg_enable    = 1'b0;
        s_axis.tvalid = 1'b0;
        m_axis.tready = 1'b1;
        for (int unsigned w = 0; w < 20; w++) begin
            @(negedge ACLK);
            #1;
            if (!busy) break;
        end
        check("end_busy", 64'(busy), 64'd0);
        check("end_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("end_frame_count", 64'(frame_count), 64'(fc0 + nf));
    endtask

    task automatic load_basic();
        in_data.delete();
        in_data.push_back(32'h0001_0002);
        in_data.push_back(32'h0003_0004);
        in_data.push_back(32'h0005_0006);
    endtask

    initial begin
        int unsigned nl, fl, nseen;

        ARESET = 1'b1;
        cfg_enable = 1'b0; cfg_null_len = '0; cfg_frame_len = '0;
        s_axis.tdata = '0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tuser = 1'b0;
        m_axis.tready = 1'b0;

        // reset holds outputs regardless of input activity
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge ACLK);
            cfg_enable = 1'($urandom_range(0, 1));
            cfg_null_len = LW'($urandom);
            cfg_frame_len = LW'($urandom);
            s_axis.tdata = $urandom;
            s_axis.tvalid = 1'($urandom_range(0, 1));
            m_axis.tready = 1'($urandom_range(0, 1));
            #1;
            check_reset_outputs($sformatf("rst%0d", i));
        end
        @(negedge ACLK);
        cfg_enable = 1'b0; s_axis.tvalid = 1'b0; m_axis.tready = 1'b1;
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
        #1;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_s_tready", 64'(s_axis.tready), 64'd0);

        // basic frame
        load_basic();
        run_frames(4, 3, 1, 0, 0, 1, 0);

        // backpressure on both sides
        run_frames(4, 3, 1, 1, 1, 1, 0);

        // back-to-back frames, enable held
        in_data.delete();
        for (int unsigned i = 1; i <= 8; i++) in_data.push_back(32'(i));
        run_frames(2, 2, 4, 0, 0, 0, 1);

        // no null period, single-sample frames
        in_data.delete();
        for (int unsigned i = 0; i < 6; i++) in_data.push_back($urandom);
        run_frames(0, 1, 6, 2, 1, 0, 0);

        // random configurations
        for (int unsigned r = 0; r < 3; r++) begin
            nl = $urandom_range(0, 5);
            fl = $urandom_range(1, 6);
            in_data.delete();
            for (int unsigned i = 0; i < fl * 3; i++) in_data.push_back($urandom);
            run_frames(nl, fl, 3, 2, 1, 0, 0);
        end

        // reset during the second null beat
        cfg_null_len = 16'd4; cfg_frame_len = 16'd3;
        cfg_enable = 1'b1; m_axis.tready = 1'b1; s_axis.tvalid = 1'b0;
        nseen = 0;
        for (int unsigned c = 0; c < 20; c++) begin
            @(negedge ACLK);
            #1;
            if (m_axis.tvalid && nseen == 1) break;
            if (m_axis.tvalid && m_axis.tready) nseen++;
        end
        check("midrst_second_null_seen", {32'(nseen), 31'd0, m_axis.tuser}, {32'd1, 31'd0, 1'b1});
        ARESET = 1'b1;
        cfg_enable = 1'b0;
        #1;
        check_reset_outputs("midrst_async");
        @(negedge ACLK);
        #1;
        check_reset_outputs("midrst_next");
        ARESET = 1'b0;
        load_basic();
        run_frames(4, 3, 1, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
